multi_bus_regfile: RTL and testbench

Parametrised successor to the fixed 6502 internal dataflow. Holds NUM_REGS registers of WIDTH bits, NUM_BUSES internal buses and one bidirectional bridge between bus 0 and bus 1. Also provides a program-counter pair with an increment/decrement carry chain and a registered external output port with a valid strobe. It sits between the control-flag decoder and the external memory interface.

---
 rtl/multi_bus_regfile_pkg.sv | 12 +
 rtl/multi_bus_regfile_bus_resolver.sv | 20 ++
 rtl/multi_bus_regfile.sv | 117 +++++++++++
 tb/tb_multi_bus_regfile.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/multi_bus_regfile_pkg.sv
// Shared definitions for the multi-bus register file: the bus index width
// helper, the default PC reset value and the default bus word type.
package dataflow_pkg;
  localparam int          DEF_WIDTH    = 8;
  localparam logic [15:0] PC_RESET_DEF = 16'hAABB;

  typedef logic [DEF_WIDTH-1:0] bus_word_t;

  function automatic int bus_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_bus_regfile_bus_resolver.sv
// Wired-OR resolution of one internal bus plus detection of two or more
// simultaneous drivers.
module bus_resolver #(
  parameter int WIDTH = 8,
  parameter int N     = 2
) (
  input  logic [N-1:0][WIDTH-1:0] drv_i,
  input  logic [N-1:0]            en_i,
  output logic [WIDTH-1:0]        val_o,
  output logic                    multi_o
);
  always_comb begin
    val_o = '0;
    for (int i = 0; i < N; i++)
      if (en_i[i]) val_o |= drv_i[i];
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(en_i & (en_i - N'(1)));
endmodule

// File: rtl/multi_bus_regfile.sv
// Parametrised register file with NUM_BUSES OR-resolved buses, a bus0/bus1
// bridge, a PC register pair with inc/dec and a registered output port.
module multi_bus_regfile
  import dataflow_pkg::*;
#(
  parameter int                   WIDTH       = 8,
  parameter int                   NUM_REGS    = 8,
  parameter int                   NUM_BUSES   = 3,
  parameter int                   PC_LO_IDX   = 0,
  parameter int                   PC_HI_IDX   = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter logic [2*WIDTH-1:0]   PC_RESET    = (2*WIDTH)'(PC_RESET_DEF),
  localparam int                  BW          = bus_idx_w(NUM_BUSES)
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [NUM_BUSES*NUM_REGS-1:0] drive_sel,
  input  logic [NUM_BUSES-1:0]          ext_drive,
  input  logic [WIDTH-1:0]              ext_in,
  input  logic                          bridge_0to1,
  input  logic                          bridge_1to0,
  input  logic [NUM_REGS-1:0]           reg_load,
  input  logic [NUM_REGS*BW-1:0]        reg_src,
  input  logic                          pc_inc,
  input  logic                          pc_dec,
  input  logic                          out_load,
  input  logic [BW-1:0]                 out_src,
  output logic [NUM_BUSES*WIDTH-1:0]    bus_val,
  output logic [NUM_REGS*WIDTH-1:0]     regs_out,
  output logic [WIDTH-1:0]              ext_out,
  output logic                          ext_out_valid,
  output logic                          conflict,
  output logic [BW-1:0]                 conflict_bus
);
  localparam int ND = NUM_REGS + 1;

  logic [NUM_REGS-1:0][WIDTH-1:0]  reg_q, reg_d, nxt;
  logic [NUM_BUSES-1:0][WIDTH-1:0] raw, bus;
  logic [NUM_BUSES-1:0]            multi;
  logic [2*WIDTH-1:0]              pc_p, pc_n;
  logic [WIDTH-1:0]                ext_out_q;
  logic                            valid_q, conflict_q;
  logic [BW-1:0]                   conflict_bus_q, first_idx;

  // Out-of-range bus indices fall through every compare and select 0.
  function automatic logic [WIDTH-1:0] pick(input logic [BW-1:0] s,
                                            input logic [NUM_BUSES-1:0][WIDTH-1:0] bv);
    pick = '0;
    for (int b = 0; b < NUM_BUSES; b++)
      if (s == BW'(b)) pick = bv[b];
  endfunction

  for (genvar b = 0; b < NUM_BUSES; b++) begin : g_bus
    logic [ND-1:0][WIDTH-1:0] drv;
    assign drv = {ext_in, reg_q};
    bus_resolver #(.WIDTH(WIDTH), .N(ND)) u_res (
      .drv_i  (drv),
      .en_i   ({ext_drive[b], drive_sel[b*NUM_REGS +: NUM_REGS]}),
      .val_o  (raw[b]),
      .multi_o(multi[b])
    );
  end

  // Bridge terms use raw values only, so opening both directions cannot loop.
  always_comb begin
    bus = raw;
    if (bridge_1to0) bus[0] = raw[0] | raw[1];
    if (bridge_0to1) bus[1] = raw[1] | raw[0];
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      nxt[r] = reg_load[r] ? pick(reg_src[r*BW +: BW], bus) : reg_q[r];
    pc_p = {nxt[PC_HI_IDX], nxt[PC_LO_IDX]};
    pc_n = pc_p;
    if (pc_inc && !pc_dec) pc_n = pc_p + (2*WIDTH)'(1);
    if (pc_dec && !pc_inc) pc_n = pc_p - (2*WIDTH)'(1);
    reg_d            = nxt;
    reg_d[PC_LO_IDX] = pc_n[WIDTH-1:0];
    reg_d[PC_HI_IDX] = pc_n[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    first_idx = '0;
    for (int b = NUM_BUSES-1; b >= 0; b--)
      if (multi[b]) first_idx = BW'(b);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == PC_LO_IDX)      reg_q[r] <= PC_RESET[WIDTH-1:0];
        else if (r == PC_HI_IDX) reg_q[r] <= PC_RESET[2*WIDTH-1:WIDTH];
        else                     reg_q[r] <= RESET_VALUE;
      end
      ext_out_q      <= '0;
      valid_q        <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_bus_q <= '0;
    end else begin
      reg_q   <= reg_d;
      valid_q <= out_load;
      if (out_load) ext_out_q <= pick(out_src, bus);
      if (!conflict_q && |multi) begin
        conflict_q     <= 1'b1;
        conflict_bus_q <= first_idx;
      end
    end
  end

  assign bus_val       = bus;
  assign regs_out      = reg_q;
  assign ext_out       = ext_out_q;
  assign ext_out_valid = valid_q;
  assign conflict      = conflict_q;
  assign conflict_bus  = conflict_bus_q;
endmodule

// File: tb/tb_multi_bus_regfile.sv
// Directed bench for multi_bus_regfile: a table of bus-resolution vectors
// plus hand-written sequences for swap, conflict, PC, output and reset.
module tb_multi_bus_regfile;
  import dataflow_pkg::*;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic [23:0] drive_sel;
  logic [2:0]  ext_drive;
  logic [7:0]  ext_in;
  logic        bridge_0to1, bridge_1to0;
  logic [7:0]  reg_load;
  logic [15:0] reg_src;
  logic        pc_inc, pc_dec, out_load;
  logic [1:0]  out_src;
  logic [23:0] bus_val;
  logic [63:0] regs_out;
  logic [7:0]  ext_out;
  logic        ext_out_valid, conflict;
  logic [1:0]  conflict_bus;

  int checks = 0;
  int errors = 0;

  multi_bus_regfile dut (
    .clk(clk), .nrst(nrst), .drive_sel(drive_sel), .ext_drive(ext_drive),
    .ext_in(ext_in), .bridge_0to1(bridge_0to1), .bridge_1to0(bridge_1to0),
    .reg_load(reg_load), .reg_src(reg_src), .pc_inc(pc_inc), .pc_dec(pc_dec),
    .out_load(out_load), .out_src(out_src), .bus_val(bus_val),
    .regs_out(regs_out), .ext_out(ext_out), .ext_out_valid(ext_out_valid),
    .conflict(conflict), .conflict_bus(conflict_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] ds;
    logic [2:0]  ed;
    bus_word_t   ei;
    logic        b01;
    logic        b10;
    logic [23:0] exp_bus;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    drive_sel = '0; ext_drive = '0; ext_in = '0; bridge_0to1 = 0; bridge_1to0 = 0;
    reg_load = '0; reg_src = '0; pc_inc = 0; pc_dec = 0; out_load = 0; out_src = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_reg(input int r, input logic [7:0] v);
    idle();
    ext_in = v; ext_drive = 3'b001; reg_load[r] = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    vecs[0] = '{24'h002010, 3'b000, 8'h00, 1'b1, 1'b1, 24'h00FFFF};
    vecs[1] = '{24'h002010, 3'b000, 8'h00, 1'b1, 1'b0, 24'h00FF0F};
    vecs[2] = '{24'h002010, 3'b000, 8'h00, 1'b0, 1'b1, 24'h00F0FF};
    vecs[3] = '{24'h002010, 3'b000, 8'h00, 1'b0, 1'b0, 24'h00F00F};
    vecs[4] = '{24'h000004, 3'b100, 8'h5A, 1'b0, 1'b0, 24'h5A003C};
    vecs[5] = '{24'h000000, 3'b000, 8'h77, 1'b1, 1'b1, 24'h000000};
    vecs[6] = '{24'h000800, 3'b000, 8'h00, 1'b1, 1'b0, 24'h00C300};

    idle();
    #2 nrst = 1'b0;
    #1;
    chk("rst_regs", regs_out, 64'h0000_0000_0000_AABB);
    chk("rst_ext_out", ext_out, 0);
    chk("rst_valid", ext_out_valid, 0);
    chk("rst_conflict", {conflict, conflict_bus}, 0);
    #20 nrst = 1'b1;
    tick();

    load_reg(2, 8'h3C); load_reg(3, 8'hC3); load_reg(4, 8'h0F); load_reg(5, 8'hF0);
    chk("preload", regs_out[47:16], 32'hF00FC33C);

    for (int i = 0; i < 7; i++) begin
      idle();
      drive_sel = vecs[i].ds; ext_drive = vecs[i].ed; ext_in = vecs[i].ei;
      bridge_0to1 = vecs[i].b01; bridge_1to0 = vecs[i].b10;
      #1;
      chk($sformatf("vec%0d_bus", i), bus_val, vecs[i].exp_bus);
      tick();
      chk($sformatf("vec%0d_noconf", i), conflict, 0);
    end

    // swap r2/r3 through bus0 and bus1 in one cycle
    idle();
    drive_sel[2] = 1'b1; drive_sel[8+3] = 1'b1;
    reg_load = 8'b0000_1100; reg_src[2*2 +: 2] = 2'd1; reg_src[3*2 +: 2] = 2'd0;
    tick();
    idle();
    chk("swap", regs_out[31:16], 16'h3CC3);

    // reg_src out of range loads zero
    load_reg(6, 8'h77);
    ext_in = 8'h55; ext_drive = 3'b111; reg_load[6] = 1'b1; reg_src[6*2 +: 2] = 2'd3;
    tick();
    idle();
    chk("src_oob", regs_out[55:48], 8'h00);

    // PC sequences
    load_reg(0, 8'hFF); load_reg(1, 8'h12);
    chk("pc_pre", regs_out[15:0], 16'h12FF);
    pc_inc = 1; tick(); idle();
    chk("pc_inc_carry", regs_out[15:0], 16'h1300);
    load_reg(0, 8'h00); load_reg(1, 8'h00);
    pc_dec = 1; tick(); idle();
    chk("pc_dec_wrap", regs_out[15:0], 16'hFFFF);
    pc_inc = 1; pc_dec = 1; tick(); idle();
    chk("pc_both", regs_out[15:0], 16'hFFFF);
    pc_inc = 1; tick(); idle();
    chk("pc_inc_wrap", regs_out[15:0], 16'h0000);
    load_reg(1, 8'h40);
    ext_in = 8'hFF; ext_drive = 3'b001; reg_load[0] = 1'b1; pc_inc = 1;
    tick(); idle();
    chk("pc_load_inc", regs_out[15:0], 16'h4100);

    // output register
    ext_in = 8'h5A; ext_drive = 3'b010; out_load = 1; out_src = 2'd1;
    tick(); idle();
    chk("out_val", {ext_out_valid, ext_out}, {1'b1, 8'h5A});
    tick();
    chk("out_valid_drop", {ext_out_valid, ext_out}, {1'b0, 8'h5A});
    ext_in = 8'h11; ext_drive = 3'b100; out_load = 1; out_src = 2'd2;
    tick();
    chk("b2b_first", {ext_out_valid, ext_out}, {1'b1, 8'h11});
    ext_in = 8'h22;
    tick(); idle();
    chk("b2b_second", {ext_out_valid, ext_out}, {1'b1, 8'h22});
    ext_in = 8'h99; ext_drive = 3'b111; out_load = 1; out_src = 2'd3;
    tick(); idle();
    chk("out_oob", {ext_out_valid, ext_out}, {1'b1, 8'h00});

    // conflict: r2 (C3) and r3 (3C) both on bus2
    drive_sel[16+2] = 1'b1; drive_sel[16+3] = 1'b1;
    #1;
    chk("conf_bus2", bus_val[23:16], 8'hFF);
    chk("conf_pre", conflict, 0);
    tick();
    idle();
    chk("conf_set", {conflict, conflict_bus}, {1'b1, 2'd2});
    drive_sel[2] = 1'b1; drive_sel[3] = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    chk("conf_sticky", {conflict, conflict_bus}, {1'b1, 2'd2});

    // asynchronous reset mid-cycle with loads pending
    ext_in = 8'hEE; ext_drive = 3'b111; reg_load = 8'hFF; out_load = 1; pc_inc = 1;
    @(posedge clk); #3;
    nrst = 1'b0;
    #1;
    chk("mid_rst_regs", regs_out, 64'h0000_0000_0000_AABB);
    chk("mid_rst_out", {ext_out_valid, ext_out}, 0);
    chk("mid_rst_conf", {conflict, conflict_bus}, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
